// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall vectors, exception codes and FSM states shared by the pipeline controller.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_NONE        = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET        = 32'h0000_000e;
    localparam logic [31:0] EXC_TLBL_REFILL = 32'h0000_0010;
    localparam logic [31:0] EXC_TLBS_REFILL = 32'h0000_0011;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles and raises a sticky flag at STALL_TIMEOUT.
module stall_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active_i,
    input  logic flush_i,
    output logic stall_timeout_o
);
    localparam logic [15:0] LIMIT = 16'(STALL_TIMEOUT);

    logic [15:0] run_q, run_d;
    logic        timeout_q, timeout_d;

    // The flag is computed from the next count so it rises on the edge closing the last stalled cycle.
    always_comb begin
        run_d     = (stall_active_i && !flush_i) ? ((run_q == LIMIT) ? LIMIT : run_q + 16'd1) : '0;
        timeout_d = timeout_q | (run_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall arbitration, exception flush/redirect and stall watchdog for the five-stage core.
// Optional perf counters (stall_cycles, flush_count) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 1023,
    parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
    parameter logic [31:0] REFILL_VECTOR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    localparam logic [3:0] HOLD_INIT = 4'(FLUSH_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  hold_q;
    logic [31:0] pc_q;
    logic        exc;
    logic [31:0] exc_pc;
    logic [5:0]  arb;

    always_comb begin
        exc    = (state_q == RUN) && (excepttype_i != EXC_NONE);
        exc_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i :
                 (excepttype_i == EXC_TLBL_REFILL || excepttype_i == EXC_TLBS_REFILL) ? REFILL_VECTOR :
                 EXC_VECTOR;
        arb    = stallreq_mem ? STALL_MEM :
                 stallreq_ex  ? STALL_EX  :
                 stallreq_id  ? STALL_ID  :
                 stallreq_if  ? STALL_IF  : STALL_NONE;
        flush  = exc || (state_q == FLUSH);
        stall  = flush ? STALL_NONE : arb;
        new_pc = (state_q == FLUSH) ? pc_q : exc ? exc_pc : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            hold_q  <= '0;
            pc_q    <= '0;
        end else if (exc) begin
            pc_q    <= exc_pc;
            hold_q  <= HOLD_INIT;
            state_q <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            hold_q  <= hold_q - 4'd1;
            state_q <= (hold_q == 4'd1) ? RUN : FLUSH;
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk             (clk),
        .rst             (rst),
        .stall_active_i  (stall != STALL_NONE),
        .flush_i         (flush),
        .stall_timeout_o (stall_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + 32'((stall != STALL_NONE));
            flush_count_q  <= flush_count_q + 32'(exc);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl using three instances (FLUSH_CYCLES 3, 4 and 1) on shared inputs.
// Inputs change on the falling edge; combinational outputs are checked 1ns later, before the next rising edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0;
    logic [31:0] exc = '0, epc = '0;

    logic [5:0]  a_stall, b_stall, c_stall;
    logic        a_flush, b_flush, c_flush;
    logic [31:0] a_pc, b_pc, c_pc;
    logic        a_to, b_to, c_to;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] a_sc, b_sc, c_sc, a_fc, b_fc, c_fc;
`endif

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(4)) u_a (
        .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .excepttype_i(exc), .cp0_epc_i(epc), .stall(a_stall), .flush(a_flush), .new_pc(a_pc), .stall_timeout(a_to)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(a_sc), .flush_count(a_fc)
`endif
    );

    pipe_ctrl #(.FLUSH_CYCLES(4)) u_b (
        .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .excepttype_i(exc), .cp0_epc_i(epc), .stall(b_stall), .flush(b_flush), .new_pc(b_pc), .stall_timeout(b_to)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(b_sc), .flush_count(b_fc)
`endif
    );

    pipe_ctrl u_c (
        .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .excepttype_i(exc), .cp0_epc_i(epc), .stall(c_stall), .flush(c_flush), .new_pc(c_pc), .stall_timeout(c_to)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(c_sc), .flush_count(c_fc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        nxt();
        chk("rst_stall", 32'(a_stall), 32'h0);
        chk("rst_flush", 32'(a_flush), 32'h0);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_to", 32'(a_to), 32'h0);
        rst = 1'b0;
        nxt();
        // stall priority
        sid = 1'b1; smem = 1'b1; #1;
        chk("prio_mem_id", 32'(a_stall), 32'h1f);
        nxt(); smem = 1'b0; #1;
        chk("prio_id", 32'(a_stall), 32'h07);
        nxt(); sex = 1'b1; #1;
        chk("prio_ex_id", 32'(a_stall), 32'h0f);
        nxt(); sid = 1'b0; sex = 1'b0; #1;
        chk("prio_none", 32'(a_stall), 32'h0);
        // syscall while ex stalls
        nxt(); sex = 1'b1; exc = 32'h8; #1;
        chk("sys_c0_flush", 32'(a_flush), 32'h1);
        chk("sys_c0_pc", a_pc, 32'h8000_0180);
        chk("sys_c0_stall", 32'(a_stall), 32'h0);
        chk("sys_c0_cflush", 32'(c_flush), 32'h1);
        nxt(); exc = 32'h0; #1;
        chk("sys_c1_flush", 32'(a_flush), 32'h1);
        chk("sys_c1_pc", a_pc, 32'h8000_0180);
        chk("sys_c1_stall", 32'(a_stall), 32'h0);
        chk("sys_c1_cflush", 32'(c_flush), 32'h0);
        chk("sys_c1_cstall", 32'(c_stall), 32'h0f);
        nxt();
        chk("sys_c2_flush", 32'(a_flush), 32'h1);
        chk("sys_c2_pc", a_pc, 32'h8000_0180);
        nxt();
        chk("sys_c3_flush", 32'(a_flush), 32'h0);
        chk("sys_c3_stall", 32'(a_stall), 32'h0f);
        chk("sys_c3_pc", a_pc, 32'h0);
        chk("sys_c3_bflush", 32'(b_flush), 32'h1);
        nxt(); sex = 1'b0; #1;
        chk("sys_c4_bflush", 32'(b_flush), 32'h0);
        // ERET with EPC changing in the second flush cycle
        nxt(); epc = 32'hBFC0_0100; exc = 32'he; #1;
        chk("eret_pc", a_pc, 32'hBFC0_0100);
        chk("eret_flush", 32'(a_flush), 32'h1);
        nxt(); exc = 32'h0; epc = 32'h1234_5678; #1;
        chk("eret_hold_pc", a_pc, 32'hBFC0_0100);
        chk("eret_c_pc", c_pc, 32'h0);
        repeat (3) nxt();
        // TLB refill, second exception during flush ignored
        exc = 32'h10; #1;
        chk("tlbl_pc", a_pc, 32'h8000_0000);
        chk("tlbl_flush", 32'(a_flush), 32'h1);
        nxt(); exc = 32'h8; #1;
        chk("tlbl_ign_pc", a_pc, 32'h8000_0000);
        chk("tlbl_c_new", c_pc, 32'h8000_0180);
        nxt(); exc = 32'h0; #1;
        chk("tlbl_c2_flush", 32'(a_flush), 32'h1);
        chk("tlbl_c2_cflush", 32'(c_flush), 32'h0);
        nxt();
        chk("tlbl_c3_flush", 32'(a_flush), 32'h0);
        nxt(); exc = 32'h11; #1;
        chk("tlbs_pc", c_pc, 32'h8000_0000);
        nxt(); exc = 32'h0;
        repeat (4) nxt();
        // watchdog: 3 stalled, 1 free, 4 stalled
        sif = 1'b1; #1;
        chk("wd_if_stall", 32'(a_stall), 32'h03);
        nxt(); nxt();
        chk("wd_run3_to", 32'(a_to), 32'h0);
        nxt(); sif = 1'b0; #1;
        chk("wd_free_to", 32'(a_to), 32'h0);
        nxt(); sif = 1'b1;
        nxt(); nxt(); nxt();
        chk("wd_run4_pre", 32'(a_to), 32'h0);
        nxt(); sif = 1'b0; #1;
        chk("wd_trip", 32'(a_to), 32'h1);
        chk("wd_b_quiet", 32'(b_to), 32'h0);
        nxt(); nxt();
        chk("wd_sticky", 32'(a_to), 32'h1);
        rst = 1'b1;
        nxt(); rst = 1'b0; #1;
        chk("wd_rst_clear", 32'(a_to), 32'h0);
        // reset in the second cycle of a 4-cycle flush
        nxt(); exc = 32'h8; #1;
        chk("rmf_c0_flush", 32'(b_flush), 32'h1);
        nxt(); exc = 32'h0; rst = 1'b1; #1;
        chk("rmf_c1_flush", 32'(b_flush), 32'h1);
        nxt(); rst = 1'b0; #1;
        chk("rmf_flush", 32'(b_flush), 32'h0);
        chk("rmf_pc", b_pc, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("rmf_fcount", b_fc, 32'h0);
        nxt(); exc = 32'h8; #1;
        nxt(); exc = 32'h0; sid = 1'b1;
        nxt(); nxt(); sid = 1'b0; #1;
        chk("perf_a_fcount", a_fc, 32'h1);
        chk("perf_c_scount", c_sc, 32'h2);
`endif
        nxt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the five-stage core. It arbitrates stall requests from IF/ID/EX/MEM into the 6-bit `stall` vector consumed by every pipeline register, including the EX-to-MEM register. It turns the MEM-stage exception type into `flush` plus a redirect PC, and holds the flush for a programmable number of cycles. It also runs a stall watchdog.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles `flush` stays high per exception (1..15).
- `STALL_TIMEOUT`, default 1023: consecutive stalled cycles before the watchdog trips (1..65535).
- `EXC_VECTOR`, default 32'h8000_0180: general exception entry.
- `REFILL_VECTOR`, default 32'h8000_0000: TLB refill entry.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high (`RstEnable`).
- `stallreq_if`, `stallreq_id`, `stallreq_ex`, `stallreq_mem`  in  1 each  stage stall requests.
- `excepttype_i`  in  32  MEM-stage exception type (`ExceptBus`); 0 means none.
- `cp0_epc_i`  in  32  current EPC from CP0.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop`.
- `flush`  out  1  kill all pipeline registers.
- `new_pc`  out  32  redirect target; valid while `flush`=1.
- `stall_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`  out  32  total stalled cycles (`PIPE_CTRL_PERF_EN` only).
- `flush_count`  out  32  exceptions taken (`PIPE_CTRL_PERF_EN` only).

## Operation
- Stall arbitration (combinational in RUN): the highest-priority request sets the vector.
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
  - Priority is mem > ex > id > if.
  - Bit5 is never set.
- Exception decode:
  - 32'h0000_000e (ERET) -> `new_pc` = `cp0_epc_i`.
  - 32'h0000_0010 / 32'h0000_0011 (TLB refill load/store) -> `REFILL_VECTOR`.
  - Any other nonzero value -> `EXC_VECTOR`.
- FSM states: RUN, FLUSH.
  - RUN with `excepttype_i`≠0:
    - `flush`=1, `new_pc` comes from the decode, and `stall`=0 regardless of requests. The exception wins over stalls.
    - The decoded PC is latched into `pc_q`.
    - Next state: FLUSH if `FLUSH_CYCLES`>1, else RUN.
    - `hold_cnt` is loaded with `FLUSH_CYCLES`-1.
  - FLUSH:
    - `flush`=1, `new_pc`=`pc_q`, `stall`=0.
    - `excepttype_i` and stall requests are ignored.
    - `hold_cnt` decrements each cycle; the FSM leaves for RUN when `hold_cnt` reaches 1. Total flush cycles = `FLUSH_CYCLES`.
  - Outside flush, `new_pc` = 32'h0.
- Watchdog:
  - 16-bit `stall_run` counts consecutive cycles with `stall`≠0.
  - It clears on any cycle with `stall`=0 or `flush`=1.
  - When it equals `STALL_TIMEOUT`, `stall_timeout` sets. Only reset clears it.
  - `stall_run` saturates at `STALL_TIMEOUT`.

## Timing
- Reset values: `stall`=0, `flush`=0, `new_pc`=0, `stall_timeout`=0, FSM=RUN, `hold_cnt`=0, `stall_run`=0, perf counters=0.
- `rst` wins over every other input in the same cycle.
- `rst` asserted mid-FLUSH drops `flush` on the following cycle.
- `stall`, `flush` and `new_pc` have zero latency from their inputs in RUN. They must settle within the cycle so the pipeline registers capture them at the same edge.
- The flush window is exactly `FLUSH_CYCLES` consecutive cycles, starting in the cycle `excepttype_i` is seen.
- After a flush, stall requests take effect in the first RUN cycle.
- `stall_timeout` rises on the edge after the `STALL_TIMEOUT`-th consecutive stalled cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `stall`≠0.
  - `flush_count` increments on each RUN→flush entry.
  - Both wrap modulo 2^32.
- `PIPE_CTRL_PERF_EN` undefined: both ports are absent and no counter logic is built.

## Structure
- Shared package, added to defines.v:
  - Stall vector constants: `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`.
  - Exception codes: `EXC_ERET`, `EXC_TLBL_REFILL`, `EXC_TLBS_REFILL`.
  - FSM state encodings.
- One sub-module, `stall_watchdog`: the `stall_run` counter plus the sticky flag, parameterized by `STALL_TIMEOUT`. The FSM and arbitration stay in `pipe_ctrl`.

## Test plan
- Stall priority: `stallreq_id`=1 and `stallreq_mem`=1 together -> `stall`=6'b011111; drop mem -> 6'b000111; drop all -> 6'b000000.
- Syscall with `FLUSH_CYCLES`=3: `excepttype_i`=32'h8 for 1 cycle while `stallreq_ex`=1 -> `flush`=1 for 3 cycles, `new_pc`=32'h8000_0180 throughout, `stall`=0, then RUN with `stall`=6'b001111.
- ERET: `cp0_epc_i`=32'hBFC0_0100, `excepttype_i`=32'he -> `new_pc`=32'hBFC0_0100 and `flush`=1. An EPC change in the second FLUSH cycle does not alter `new_pc`.
- TLB refill: `excepttype_i`=32'h10 -> `new_pc`=32'h8000_0000. A second exception arriving during FLUSH is ignored.
- Watchdog with `STALL_TIMEOUT`=4:
  - 3 stalled cycles, 1 free cycle, then 4 stalled cycles -> `stall_timeout` rises only after the 4-cycle run.
  - It stays high after the stalls end.
  - `rst` clears it.
- Reset mid-flush with `FLUSH_CYCLES`=4: assert `rst` in the 2nd flush cycle -> next cycle `flush`=0, `new_pc`=0, and with `PIPE_CTRL_PERF_EN` `flush_count`=0.
